// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ntt_pkg
// Brief   : Shared NTT constants and coefficient type for the butterflies.
// Rev     : 1.0  initial release
// ============================================================================
package ntt_pkg;
    localparam int unsigned LOGQ = 17;
    localparam int unsigned Q    = 65537;
    localparam longint unsigned MU = (64'd1 << (2 * LOGQ)) / 64'(Q);

    typedef logic [LOGQ-1:0] coeff_t;
endpackage
`default_nettype wire

// File: rtl/modred_barrett.sv
`default_nettype none
// ============================================================================
// Module  : modred_barrett
// Brief   : Combinational Barrett reduction of a 2*LOGQ-bit product mod Q.
// Rev     : 1.0  initial release
// ============================================================================
module modred_barrett
    import ntt_pkg::*;
#(
    parameter int unsigned LOGQ = ntt_pkg::LOGQ,
    parameter int unsigned Q    = ntt_pkg::Q
) (
    input  logic [2*LOGQ-1:0] i_p,
    output logic [LOGQ-1:0]   o_r
);
    localparam int unsigned     PW   = 2 * LOGQ;
    localparam int unsigned     XW   = 3 * LOGQ + 1;
    localparam longint unsigned MU_L = (64'd1 << PW) / 64'(Q);

    logic [XW-1:0]   w_prod;
    logic [LOGQ:0]   w_qe;
    logic [PW-1:0]   w_qq;
    logic [PW-1:0]   w_r0;
    logic [PW-1:0]   w_r1;
    logic [PW-1:0]   w_r2;

    // The quotient estimate undershoots by at most 2, so r0 < 3Q.
    assign w_prod = XW'(i_p) * XW'(MU_L);
    assign w_qe   = (LOGQ+1)'(w_prod >> PW);
    assign w_qq   = PW'(w_qe) * PW'(Q);
    assign w_r0   = i_p - w_qq;
    assign w_r1   = (w_r0 >= PW'(Q)) ? (w_r0 - PW'(Q)) : w_r0;
    assign w_r2   = (w_r1 >= PW'(Q)) ? (w_r1 - PW'(Q)) : w_r1;
    assign o_r    = LOGQ'(w_r2);
endmodule
`default_nettype wire

// File: rtl/intt_gs_butterfly.sv
`default_nettype none
// ============================================================================
// Module  : intt_gs_butterfly
// Brief   : 3-stage Gentleman-Sande butterfly: u=(a+b), v=(a-b)*w mod Q.
// Rev     : 1.0  initial release
// ============================================================================
module intt_gs_butterfly
    import ntt_pkg::*;
#(
    parameter int unsigned LOGQ = ntt_pkg::LOGQ,
    parameter int unsigned Q    = ntt_pkg::Q,
    parameter int unsigned TAGW = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] in_a,
    input  logic [LOGQ-1:0] in_b,
    input  logic [LOGQ-1:0] in_w,
    input  logic            in_half,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] out_u,
    output logic [LOGQ-1:0] out_v,
    output logic [TAGW-1:0] out_tag
);
    localparam logic [LOGQ:0] QX = (LOGQ+1)'(Q);

    function automatic logic [LOGQ-1:0] halve(input logic [LOGQ-1:0] x);
        logic [LOGQ:0] t;
        t = x[0] ? ({1'b0, x} + QX) : {1'b0, x};
        return LOGQ'(t >> 1);
    endfunction

    logic            w_stall;
    logic [LOGQ:0]   w_sum;
    logic [LOGQ:0]   w_dif;
    logic [LOGQ-1:0] w_s;
    logic [LOGQ-1:0] w_d;
    logic [LOGQ-1:0] w_sh;
    logic [LOGQ-1:0] w_dh;
    logic [2*LOGQ-1:0] w_p;
    logic [LOGQ-1:0] w_v;

    logic            r_v1, r_v2, r_v3;
    logic [LOGQ-1:0] r_s1, r_d1, r_w1;
    logic            r_h1;
    logic [TAGW-1:0] r_t1, r_t2, r_t3;
    logic [LOGQ-1:0] r_sh2;
    logic [2*LOGQ-1:0] r_p2;
    logic [LOGQ-1:0] r_u3, r_v3d;

    // Rigid shift pipeline: a stalled output freezes every stage.
    assign w_stall  = r_v3 && !out_ready;
    assign in_ready = !w_stall;

    assign w_sum = {1'b0, in_a} + {1'b0, in_b};
    assign w_s   = (w_sum >= QX) ? LOGQ'(w_sum - QX) : LOGQ'(w_sum);
    assign w_dif = {1'b0, in_a} - {1'b0, in_b};
    assign w_d   = w_dif[LOGQ] ? LOGQ'(w_dif + QX) : LOGQ'(w_dif);

    assign w_sh = r_h1 ? halve(r_s1) : r_s1;
    assign w_dh = r_h1 ? halve(r_d1) : r_d1;
    assign w_p  = (2*LOGQ)'(w_dh) * (2*LOGQ)'(r_w1);

    modred_barrett #(
        .LOGQ (LOGQ),
        .Q    (Q)
    ) u_modred (
        .i_p (r_p2),
        .o_r (w_v)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_s1  <= '0;
            r_d1  <= '0;
            r_w1  <= '0;
            r_h1  <= 1'b0;
            r_t1  <= '0;
            r_sh2 <= '0;
            r_p2  <= '0;
            r_t2  <= '0;
            r_u3  <= '0;
            r_v3d <= '0;
            r_t3  <= '0;
        end else if (!w_stall) begin
            r_v1  <= in_valid;
            r_s1  <= w_s;
            r_d1  <= w_d;
            r_w1  <= in_w;
            r_h1  <= in_half;
            r_t1  <= in_tag;
            r_v2  <= r_v1;
            r_sh2 <= w_sh;
            r_p2  <= w_p;
            r_t2  <= r_t1;
            r_v3  <= r_v2;
            r_u3  <= r_sh2;
            r_v3d <= w_v;
            r_t3  <= r_t2;
        end
    end

    assign out_valid = r_v3;
    assign out_u     = r_u3;
    assign out_v     = r_v3d;
    assign out_tag   = r_t3;
endmodule
`default_nettype wire

// File: tb/tb_intt_gs_butterfly.sv
`default_nettype none
// ============================================================================
// Module  : tb_intt_gs_butterfly
// Brief   : Self-checking bench for intt_gs_butterfly against a modular model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_intt_gs_butterfly;
    localparam int unsigned Q     = 65537;
    localparam int          NRAND = 20000;

    typedef struct {
        logic [16:0] u;
        logic [16:0] v;
        logic [9:0]  t;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] in_a = '0;
    logic [16:0] in_b = '0;
    logic [16:0] in_w = '0;
    logic        in_half = 1'b0;
    logic [9:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [16:0] out_u;
    logic [16:0] out_v;
    logic [9:0]  out_tag;

    int checks = 0;
    int errors = 0;
    res_t q[$];

    always #5 clk = ~clk;

    intt_gs_butterfly #(.LOGQ(17), .Q(65537), .TAGW(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_w      (in_w),
        .in_half   (in_half),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_u     (out_u),
        .out_v     (out_v),
        .out_tag   (out_tag)
    );

    // Reference: plain modular arithmetic; halving is multiplication by 2^-1.
    function automatic res_t ref_op(input longint a, input longint b, input longint w,
                                    input bit h, input logic [9:0] t);
        res_t   r;
        longint inv2, u, v;
        inv2 = (longint'(Q) + 1) / 2;
        u = (a + b) % Q;
        v = (((a - b + Q) % Q) * w) % Q;
        if (h) begin
            u = (u * inv2) % Q;
            v = (v * inv2) % Q;
        end
        r.u = 17'(u);
        r.v = 17'(v);
        r.t = t;
        return r;
    endfunction

    function automatic logic [16:0] rnd_coeff();
        case ($urandom_range(0, 7))
            0:       return 17'd0;
            1:       return 17'(Q - 1);
            default: return 17'($urandom_range(0, Q - 1));
        endcase
    endfunction

    task automatic drive(input logic iv, input logic [16:0] a, input logic [16:0] b,
                         input logic [16:0] w, input logic h, input logic [9:0] t,
                         input logic ordy, output logic acc_in, output logic acc_out);
        @(negedge clk);
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        in_w      = w;
        in_half   = h;
        in_tag    = t;
        out_ready = ordy;
        #1;
        acc_in  = in_valid && in_ready;
        acc_out = out_valid && out_ready;
        if (acc_in)
            assert (in_a < Q && in_b < Q && in_w < Q) else $error("illegal operand");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (out_u !== 17'd0) begin errors++; $display("FAIL reset_u got %0d want 0", out_u); end
        checks++; if (out_v !== 17'd0) begin errors++; $display("FAIL reset_v got %0d want 0", out_v); end
        checks++; if (out_tag !== 10'd0) begin errors++; $display("FAIL reset_tag got %0d want 0", out_tag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [16:0] ta[8] = '{17'd5, 17'd3, 17'd5, 17'd65536, 17'd65536, 17'd1234, 17'd100, 17'd10};
        logic [16:0] tb[8] = '{17'd3, 17'd5, 17'd2, 17'd0, 17'd65536, 17'd1234, 17'd7, 17'd65536};
        logic [16:0] tw[8] = '{17'd2, 17'd1, 17'd1, 17'd65536, 17'd65536, 17'd999, 17'd0, 17'd3};
        logic        th[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [16:0] eu[8] = '{17'd8, 17'd8, 17'd32772, 17'd65536, 17'd65535, 17'd2468, 17'd32822, 17'd32773};
        logic [16:0] ev[8] = '{17'd4, 17'd65535, 17'd32770, 17'd1, 17'd0, 17'd0, 17'd0, 17'd32785};
        logic ai, ao, got;
        int   lat;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ta[i], tb[i], tw[i], th[i], 10'(7 + i), 1'b1, ai, ao);
            got = 1'b0;
            lat = 0;
            for (int k = 1; k <= 8 && !got; k++) begin
                drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, ai, ao);
                if (ao) begin
                    got = 1'b1;
                    lat = k;
                    checks++; if (lat != 3) begin errors++; $display("FAIL dir%0d_latency got %0d want 3", i, lat); end
                    checks++; if (out_u !== eu[i]) begin errors++; $display("FAIL dir%0d_u got %0d want %0d", i, out_u, eu[i]); end
                    checks++; if (out_v !== ev[i]) begin errors++; $display("FAIL dir%0d_v got %0d want %0d", i, out_v, ev[i]); end
                    checks++; if (out_tag !== 10'(7 + i)) begin errors++; $display("FAIL dir%0d_tag got %0d want %0d", i, out_tag, 7 + i); end
                end
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL dir%0d_timeout got no output want one", i);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] da[10], db[10], dw[10];
        logic        dh[10];
        logic ai, ao, ordy, was_stall;
        int   nxt, rcv;
        res_t e, held;
        for (int i = 0; i < 10; i++) begin
            da[i] = rnd_coeff(); db[i] = rnd_coeff(); dw[i] = rnd_coeff();
            dh[i] = 1'($urandom_range(0, 1));
        end
        q.delete();
        nxt = 0; rcv = 0; was_stall = 1'b0;
        held = '{u: '0, v: '0, t: '0};
        for (int c = 0; c < 60 && rcv < 10; c++) begin
            ordy = !(c >= 4 && c <= 8);
            if (nxt < 10)
                drive(1'b1, da[nxt], db[nxt], dw[nxt], dh[nxt], 10'(nxt), ordy, ai, ao);
            else
                drive(1'b0, '0, '0, '0, 1'b0, '0, ordy, ai, ao);
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++; $display("FAIL b2b_ready c%0d got %0b want %0b", c, in_ready, !(out_valid && !out_ready));
            end
            if (was_stall) begin
                checks++;
                if (!out_valid || out_u !== held.u || out_v !== held.v || out_tag !== held.t) begin
                    errors++; $display("FAIL b2b_hold c%0d got %0b/%0d/%0d/%0d want 1/%0d/%0d/%0d",
                                       c, out_valid, out_u, out_v, out_tag, held.u, held.v, held.t);
                end
            end
            was_stall = out_valid && !out_ready;
            held = '{u: out_u, v: out_v, t: out_tag};
            if (ao) begin
                e = q.pop_front();
                rcv++;
                checks++;
                if (out_u !== e.u || out_v !== e.v || out_tag !== e.t) begin
                    errors++; $display("FAIL b2b_data got %0d/%0d/%0d want %0d/%0d/%0d",
                                       out_u, out_v, out_tag, e.u, e.v, e.t);
                end
            end
            if (ai) begin
                q.push_back(ref_op(da[nxt], db[nxt], dw[nxt], dh[nxt], 10'(nxt)));
                nxt++;
            end
        end
        checks++;
        if (rcv != 10 || q.size() != 0) begin
            errors++; $display("FAIL b2b_count got %0d want 10", rcv);
        end
    endtask

    task automatic test_reset_mid();
        logic ai, ao, got;
        res_t e;
        for (int i = 0; i < 3; i++)
            drive(1'b1, 17'(100 + i), 17'd1, 17'd2, 1'b0, 10'(500 + i), 1'b1, ai, ao);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_u !== 17'd0 || out_v !== 17'd0 || out_tag !== 10'd0) begin
            errors++; $display("FAIL midrst_clear got %0b/%0d/%0d/%0d want 0/0/0/0", out_valid, out_u, out_v, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 17'd40000, 17'd50000, 17'd12345, 1'b1, 10'd999, 1'b1, ai, ao);
        e = ref_op(40000, 50000, 12345, 1'b1, 10'd999);
        got = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, ai, ao);
            if (ao) begin
                got = 1'b1;
                checks++; if (k != 3) begin errors++; $display("FAIL midrst_latency got %0d want 3", k); end
                checks++;
                if (out_u !== e.u || out_v !== e.v || out_tag !== e.t) begin
                    errors++; $display("FAIL midrst_data got %0d/%0d/%0d want %0d/%0d/%0d",
                                       out_u, out_v, out_tag, e.u, e.v, e.t);
                end
            end
        end
        if (!got) begin
            checks++; errors++; $display("FAIL midrst_timeout got no output want one");
        end
    endtask

    task automatic test_random();
        logic [16:0] a, b, w;
        logic        h, iv, ordy, ai, ao, was_stall;
        logic [9:0]  t;
        int          sent, rcv, drain;
        res_t        e, held;
        q.delete();
        sent = 0; rcv = 0; was_stall = 1'b0;
        held = '{u: '0, v: '0, t: '0};
        drain = 0;
        while ((sent < NRAND || q.size() != 0) && drain < 40) begin
            a = rnd_coeff(); b = rnd_coeff(); w = rnd_coeff();
            h = 1'($urandom_range(0, 1));
            t = 10'($urandom);
            iv   = (sent < NRAND) && ($urandom_range(0, 3) != 0);
            ordy = (sent >= NRAND) || ($urandom_range(0, 9) < 7);
            if (sent >= NRAND) drain++;
            drive(iv, a, b, w, h, t, ordy, ai, ao);
            if (was_stall) begin
                checks++;
                if (!out_valid || out_u !== held.u || out_v !== held.v || out_tag !== held.t) begin
                    errors++; $display("FAIL rand_hold got %0b/%0d/%0d/%0d want 1/%0d/%0d/%0d",
                                       out_valid, out_u, out_v, out_tag, held.u, held.v, held.t);
                end
            end
            was_stall = out_valid && !out_ready;
            held = '{u: out_u, v: out_v, t: out_tag};
            if (ao) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_extra got tag %0d want none", out_tag);
                end else begin
                    e = q.pop_front();
                    rcv++;
                    if (out_u !== e.u || out_v !== e.v || out_tag !== e.t) begin
                        errors++; $display("FAIL rand_data got %0d/%0d/%0d want %0d/%0d/%0d",
                                           out_u, out_v, out_tag, e.u, e.v, e.t);
                    end
                end
            end
            if (ai) begin
                q.push_back(ref_op(a, b, w, h, t));
                sent++;
            end
        end
        checks++;
        if (rcv != NRAND || q.size() != 0) begin
            errors++; $display("FAIL rand_count got %0d want %0d", rcv, NRAND);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
